// File: rtl/decode_pkg.sv
// Shared decode constants and control-bundle type for the instruction decode queue.
// DECODE_ILLEGAL_EN (optional) adds an illegal-encoding flag to the decoded bundle.
package decode_pkg;

  localparam int unsigned INSTR_W  = 32;
  localparam int unsigned OP_W     = 6;
  localparam int unsigned REG_W    = 5;
  localparam int unsigned IMM_W    = 16;
  localparam int unsigned ADDR_W   = 26;
  localparam int unsigned ALU_OP_W = 3;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OP_W-1:0] OP_J     = 6'h02;
  localparam logic [OP_W-1:0] OP_JAL   = 6'h03;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OP_W-1:0] OP_BNE   = 6'h05;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
  localparam logic [OP_W-1:0] OP_XORI  = 6'h0E;
  localparam logic [OP_W-1:0] OP_LW    = 6'h23;
  localparam logic [OP_W-1:0] OP_SW    = 6'h2B;

  localparam logic [OP_W-1:0] FN_JR  = 6'h08;
  localparam logic [OP_W-1:0] FN_ADD = 6'h20;
  localparam logic [OP_W-1:0] FN_SUB = 6'h22;
  localparam logic [OP_W-1:0] FN_XOR = 6'h26;
  localparam logic [OP_W-1:0] FN_SLT = 6'h2A;

  localparam logic [ALU_OP_W-1:0] ALU_ADD = 3'd0;
  localparam logic [ALU_OP_W-1:0] ALU_SUB = 3'd1;
  localparam logic [ALU_OP_W-1:0] ALU_XOR = 3'd2;
  localparam logic [ALU_OP_W-1:0] ALU_SLT = 3'd3;

  typedef struct packed {
    logic [ALU_OP_W-1:0] alu_op;
    logic                alu_imm;
    logic                reg_write;
    logic                reg_dst;
    logic                mem_to_reg;
    logic                mem_write;
    logic                branch_eq;
    logic                branch_ne;
    logic                jump;
    logic                jump_link;
    logic                jump_reg;
  } ctrl_t;

endpackage

// File: rtl/instr_decode_queue_if.sv
// Fetch-side push and decode-side bundle signals of the instruction decode queue.
// DECODE_ILLEGAL_EN adds the illegal flag to the bundle.
interface instr_decode_queue_if
  import decode_pkg::*;
#(
  parameter int unsigned PC_W = 32
) ();

  logic                in_valid;
  logic                in_ready;
  logic [INSTR_W-1:0]  in_instr;
  logic [PC_W-1:0]     in_pc;
  logic                flush;
  logic                out_valid;
  logic                out_ready;
  logic [OP_W-1:0]     op;
  logic [REG_W-1:0]    rs;
  logic [REG_W-1:0]    rt;
  logic [REG_W-1:0]    rd;
  logic [IMM_W-1:0]    imm;
  logic [ADDR_W-1:0]   addr;
  logic [ALU_OP_W-1:0] alu_op;
  logic                alu_imm;
  logic                reg_write;
  logic                reg_dst;
  logic                mem_to_reg;
  logic                mem_write;
  logic                branch_eq;
  logic                branch_ne;
  logic                jump;
  logic                jump_link;
  logic                jump_reg;
  logic [PC_W-1:0]     branch_target;
  logic [PC_W-1:0]     jump_target;
`ifdef DECODE_ILLEGAL_EN
  logic                illegal;
`endif

  modport slave (
    input  in_valid, in_instr, in_pc, flush, out_ready,
    output in_ready, out_valid, op, rs, rt, rd, imm, addr, alu_op, alu_imm,
           reg_write, reg_dst, mem_to_reg, mem_write, branch_eq, branch_ne,
           jump, jump_link, jump_reg, branch_target, jump_target
`ifdef DECODE_ILLEGAL_EN
         , illegal
`endif
  );

  modport master (
    output in_valid, in_instr, in_pc, flush, out_ready,
    input  in_ready, out_valid, op, rs, rt, rd, imm, addr, alu_op, alu_imm,
           reg_write, reg_dst, mem_to_reg, mem_write, branch_eq, branch_ne,
           jump, jump_link, jump_reg, branch_target, jump_target
`ifdef DECODE_ILLEGAL_EN
         , illegal
`endif
  );

endinterface

// File: rtl/instr_decode_comb.sv
// Pure combinational MIPS-subset decode: control bundle plus branch/jump targets.
// DECODE_ILLEGAL_EN flags unlisted encodings and suppresses their writes.
module instr_decode_comb
  import decode_pkg::*;
#(
  parameter int unsigned PC_W = 32
) (
  input  logic [INSTR_W-1:0] instr_i,
  input  logic [PC_W-1:0]    pc_i,
  output ctrl_t              ctrl_c_o,
  output logic [PC_W-1:0]    branch_target_c_o,
  output logic [PC_W-1:0]    jump_target_c_o
`ifdef DECODE_ILLEGAL_EN
, output logic               illegal_c_o
`endif
);

  logic [OP_W-1:0] op_c;
  logic [OP_W-1:0] funct_c;
  logic [PC_W-1:0] pc4_c;
  logic [PC_W-1:0] imm_sext_c;
  ctrl_t           ctrl_c;

  assign op_c    = instr_i[31:26];
  assign funct_c = instr_i[5:0];

  // Control table; unlisted encodings fall through as all-zero controls.
  always_comb begin
    ctrl_c        = '0;
    ctrl_c.alu_op = ALU_ADD;
    case (op_c)
      OP_RTYPE: begin
        case (funct_c)
          FN_ADD: begin ctrl_c.reg_write = 1'b1; ctrl_c.reg_dst = 1'b1; end
          FN_SUB: begin ctrl_c.reg_write = 1'b1; ctrl_c.reg_dst = 1'b1; ctrl_c.alu_op = ALU_SUB; end
          FN_XOR: begin ctrl_c.reg_write = 1'b1; ctrl_c.reg_dst = 1'b1; ctrl_c.alu_op = ALU_XOR; end
          FN_SLT: begin ctrl_c.reg_write = 1'b1; ctrl_c.reg_dst = 1'b1; ctrl_c.alu_op = ALU_SLT; end
          FN_JR:  ctrl_c.jump_reg = 1'b1;
          default: ;
        endcase
      end
      OP_ADDI: begin ctrl_c.alu_imm = 1'b1; ctrl_c.reg_write = 1'b1; end
      OP_XORI: begin ctrl_c.alu_imm = 1'b1; ctrl_c.reg_write = 1'b1; ctrl_c.alu_op = ALU_XOR; end
      OP_LW:   begin ctrl_c.alu_imm = 1'b1; ctrl_c.reg_write = 1'b1; ctrl_c.mem_to_reg = 1'b1; end
      OP_SW:   begin ctrl_c.alu_imm = 1'b1; ctrl_c.mem_write = 1'b1; end
      OP_BEQ:  begin ctrl_c.alu_op = ALU_SUB; ctrl_c.branch_eq = 1'b1; end
      OP_BNE:  begin ctrl_c.alu_op = ALU_SUB; ctrl_c.branch_ne = 1'b1; end
      OP_J:    ctrl_c.jump = 1'b1;
      OP_JAL:  begin ctrl_c.jump = 1'b1; ctrl_c.jump_link = 1'b1; ctrl_c.reg_write = 1'b1; end
      default: ;
    endcase
  end

`ifdef DECODE_ILLEGAL_EN
  // Every listed encoding raises at least one control bit, so an all-zero bundle marks it unlisted.
  always_comb begin
    illegal_c_o = (ctrl_c == '0);
    ctrl_c_o    = ctrl_c;
    if (illegal_c_o) begin
      ctrl_c_o.reg_write = 1'b0;
      ctrl_c_o.mem_write = 1'b0;
    end
  end
`else
  assign ctrl_c_o = ctrl_c;
`endif

  assign pc4_c             = pc_i + PC_W'(4);
  assign imm_sext_c        = {{(PC_W-IMM_W){instr_i[15]}}, instr_i[15:0]};
  assign branch_target_c_o = pc4_c + (imm_sext_c << 2);

  generate
    if (PC_W > 28) begin : g_jt_upper
      assign jump_target_c_o = {pc4_c[PC_W-1:28], instr_i[25:0], 2'b00};
    end else begin : g_jt_flat
      assign jump_target_c_o = {instr_i[25:0], 2'b00};
    end
  endgenerate

endmodule

// File: rtl/instr_decode_queue.sv
// DEPTH-entry instruction/PC FIFO feeding a registered decode stage with stall and flush.
// DECODE_ILLEGAL_EN adds the illegal flag to the registered bundle.
module instr_decode_queue
  import decode_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PC_W  = 32
) (
  input logic                  clk,
  input logic                  rst_n,
  instr_decode_queue_if.slave  bus
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [REG_W-1:0]  rs;
    logic [REG_W-1:0]  rt;
    logic [REG_W-1:0]  rd;
    logic [IMM_W-1:0]  imm;
    logic [ADDR_W-1:0] addr;
    ctrl_t             ctrl;
    logic [PC_W-1:0]   branch_target;
    logic [PC_W-1:0]   jump_target;
`ifdef DECODE_ILLEGAL_EN
    logic              illegal;
`endif
  } bundle_t;

  logic [INSTR_W-1:0] instr_mem_q [DEPTH];
  logic [PC_W-1:0]    pc_mem_q    [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  bundle_t            bundle_q, bundle_d;

  logic               push_c;
  logic               load_c;
  logic [INSTR_W-1:0] head_instr_c;
  logic [PC_W-1:0]    head_pc_c;
  ctrl_t              head_ctrl_c;
  logic [PC_W-1:0]    head_bt_c;
  logic [PC_W-1:0]    head_jt_c;
  bundle_t            head_bundle_c;
`ifdef DECODE_ILLEGAL_EN
  logic               head_illegal_c;
`endif

  assign head_instr_c = instr_mem_q[rd_ptr_q];
  assign head_pc_c    = pc_mem_q[rd_ptr_q];

  instr_decode_comb #(.PC_W(PC_W)) u_decode (
    .instr_i           (head_instr_c),
    .pc_i              (head_pc_c),
    .ctrl_c_o          (head_ctrl_c),
    .branch_target_c_o (head_bt_c),
    .jump_target_c_o   (head_jt_c)
`ifdef DECODE_ILLEGAL_EN
  , .illegal_c_o       (head_illegal_c)
`endif
  );

  always_comb begin
    head_bundle_c               = '0;
    head_bundle_c.op            = head_instr_c[31:26];
    head_bundle_c.rs            = head_instr_c[25:21];
    head_bundle_c.rt            = head_instr_c[20:16];
    head_bundle_c.rd            = head_instr_c[15:11];
    head_bundle_c.imm           = head_instr_c[15:0];
    head_bundle_c.addr          = head_instr_c[25:0];
    head_bundle_c.ctrl          = head_ctrl_c;
    head_bundle_c.branch_target = head_bt_c;
    head_bundle_c.jump_target   = head_jt_c;
`ifdef DECODE_ILLEGAL_EN
    head_bundle_c.illegal       = head_illegal_c;
`endif
  end

  // Flush wins over push and load; a pop never frees a slot for the same cycle's push.
  always_comb begin
    push_c      = bus.in_valid & in_ready_q & ~bus.flush;
    load_c      = (count_q != '0) & (~out_valid_q | bus.out_ready) & ~bus.flush;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    out_valid_d = out_valid_q;
    bundle_d    = bundle_q;
    in_ready_d  = in_ready_q;
    if (bus.flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      out_valid_d = 1'b0;
      in_ready_d  = 1'b1;
    end else begin
      wr_ptr_d = wr_ptr_q + PTR_W'(push_c);
      rd_ptr_d = rd_ptr_q + PTR_W'(load_c);
      count_d  = count_q + CNT_W'(push_c) - CNT_W'(load_c);
      if (load_c) begin
        out_valid_d = 1'b1;
        bundle_d    = head_bundle_c;
      end else if (bus.out_ready) begin
        out_valid_d = 1'b0;
      end
      in_ready_d = (count_d != CNT_W'(DEPTH));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      bundle_q    <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      bundle_q    <= bundle_d;
    end
  end

  // Storage needs no reset: entries are only read once counted.
  always_ff @(posedge clk) begin
    if (push_c) begin
      instr_mem_q[wr_ptr_q] <= bus.in_instr;
      pc_mem_q[wr_ptr_q]    <= bus.in_pc;
    end
  end

  assign bus.in_ready      = in_ready_q;
  assign bus.out_valid     = out_valid_q;
  assign bus.op            = bundle_q.op;
  assign bus.rs            = bundle_q.rs;
  assign bus.rt            = bundle_q.rt;
  assign bus.rd            = bundle_q.rd;
  assign bus.imm           = bundle_q.imm;
  assign bus.addr          = bundle_q.addr;
  assign bus.alu_op        = bundle_q.ctrl.alu_op;
  assign bus.alu_imm       = bundle_q.ctrl.alu_imm;
  assign bus.reg_write     = bundle_q.ctrl.reg_write;
  assign bus.reg_dst       = bundle_q.ctrl.reg_dst;
  assign bus.mem_to_reg    = bundle_q.ctrl.mem_to_reg;
  assign bus.mem_write     = bundle_q.ctrl.mem_write;
  assign bus.branch_eq     = bundle_q.ctrl.branch_eq;
  assign bus.branch_ne     = bundle_q.ctrl.branch_ne;
  assign bus.jump          = bundle_q.ctrl.jump;
  assign bus.jump_link     = bundle_q.ctrl.jump_link;
  assign bus.jump_reg      = bundle_q.ctrl.jump_reg;
  assign bus.branch_target = bundle_q.branch_target;
  assign bus.jump_target   = bundle_q.jump_target;
`ifdef DECODE_ILLEGAL_EN
  assign bus.illegal       = bundle_q.illegal;
`endif

endmodule

// File: tb/tb_instr_decode_queue.sv
// Self-checking bench for instr_decode_queue: directed scenarios then randomized traffic
// against a queue-based reference model. DECODE_ILLEGAL_EN enables illegal-flag checks.
module tb_instr_decode_queue;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned PC_W  = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  instr_decode_queue_if #(.PC_W(PC_W)) bus ();

  instr_decode_queue #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [5:0]  op;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    logic [25:0] addr;
    logic [2:0]  alu_op;
    logic        alu_imm, reg_write, reg_dst, mem_to_reg, mem_write;
    logic        branch_eq, branch_ne, jump, jump_link, jump_reg;
    logic [31:0] bt, jt;
    logic        illegal;
  } exp_t;

  int passed = 0;
  int failed = 0;
  int total  = 0;
  int dut_consumed = 0;

  logic [63:0] mq[$];
  bit          m_ov = 1'b0;
  exp_t        m_out = '0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] expv);
    total++;
    assert (obs === expv) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic exp_t observe();
    exp_t o;
    o = '0;
    o.op = bus.op; o.rs = bus.rs; o.rt = bus.rt; o.rd = bus.rd;
    o.imm = bus.imm; o.addr = bus.addr; o.alu_op = bus.alu_op;
    o.alu_imm = bus.alu_imm; o.reg_write = bus.reg_write; o.reg_dst = bus.reg_dst;
    o.mem_to_reg = bus.mem_to_reg; o.mem_write = bus.mem_write;
    o.branch_eq = bus.branch_eq; o.branch_ne = bus.branch_ne;
    o.jump = bus.jump; o.jump_link = bus.jump_link; o.jump_reg = bus.jump_reg;
    o.bt = bus.branch_target; o.jt = bus.jump_target;
`ifdef DECODE_ILLEGAL_EN
    o.illegal = bus.illegal;
`endif
    return o;
  endfunction

  // Reference decode straight from the instruction table.
  function automatic exp_t ref_decode(input logic [63:0] ent);
    exp_t        r;
    logic [31:0] ins, pc, pc4, sx;
    bit          known;
    ins = ent[63:32];
    pc  = ent[31:0];
    r = '0;
    r.op = ins[31:26]; r.rs = ins[25:21]; r.rt = ins[20:16]; r.rd = ins[15:11];
    r.imm = ins[15:0]; r.addr = ins[25:0];
    pc4  = pc + 32'd4;
    sx   = {{16{ins[15]}}, ins[15:0]};
    r.bt = pc4 + sx * 32'd4;
    r.jt = {pc4[31:28], ins[25:0], 2'b00};
    known = 1'b1;
    case (ins[31:26])
      6'h00: case (ins[5:0])
        6'h20: begin r.reg_write = 1; r.reg_dst = 1; end
        6'h22: begin r.reg_write = 1; r.reg_dst = 1; r.alu_op = 3'd1; end
        6'h26: begin r.reg_write = 1; r.reg_dst = 1; r.alu_op = 3'd2; end
        6'h2A: begin r.reg_write = 1; r.reg_dst = 1; r.alu_op = 3'd3; end
        6'h08: r.jump_reg = 1;
        default: known = 1'b0;
      endcase
      6'h08: begin r.alu_imm = 1; r.reg_write = 1; end
      6'h0E: begin r.alu_imm = 1; r.reg_write = 1; r.alu_op = 3'd2; end
      6'h23: begin r.alu_imm = 1; r.reg_write = 1; r.mem_to_reg = 1; end
      6'h2B: begin r.alu_imm = 1; r.mem_write = 1; end
      6'h04: begin r.alu_op = 3'd1; r.branch_eq = 1; end
      6'h05: begin r.alu_op = 3'd1; r.branch_ne = 1; end
      6'h02: r.jump = 1;
      6'h03: begin r.jump = 1; r.jump_link = 1; r.reg_write = 1; end
      default: known = 1'b0;
    endcase
`ifdef DECODE_ILLEGAL_EN
    r.illegal = !known;
`endif
    return r;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [5:0]  ops [12] = '{6'h00, 6'h00, 6'h00, 6'h08, 6'h0E, 6'h23, 6'h2B,
                               6'h04, 6'h05, 6'h02, 6'h03, 6'h3F};
    logic [5:0]  fns [6] = '{6'h20, 6'h22, 6'h26, 6'h2A, 6'h08, 6'h11};
    logic [31:0] w;
    w = $urandom;
    if ($urandom_range(0, 7) == 0) return w;
    w[31:26] = ops[$urandom_range(0, 11)];
    if (w[31:26] == 6'h00) w[5:0] = fns[$urandom_range(0, 5)];
    return w;
  endfunction

  task automatic drive(input bit v, input logic [31:0] ins, input logic [31:0] pc,
                       input bit ordy, input bit fl);
    bus.in_valid  = v;
    bus.in_instr  = ins;
    bus.in_pc     = pc;
    bus.out_ready = ordy;
    bus.flush     = fl;
  endtask

  // One clock: advance the model with the driven inputs, then compare just after the edge.
  task automatic step();
    int sz;
    bit ld, ps;
    if (bus.out_valid === 1'b1 && bus.out_ready) dut_consumed++;
    @(posedge clk);
    if (bus.flush) begin
      mq.delete();
      m_ov = 1'b0;
    end else begin
      sz = mq.size();
      ld = (sz != 0) && (!m_ov || bus.out_ready);
      ps = bus.in_valid && (sz < DEPTH);
      if (ld) begin
        m_out = ref_decode(mq.pop_front());
        m_ov  = 1'b1;
      end else if (bus.out_ready) begin
        m_ov = 1'b0;
      end
      if (ps) mq.push_back({bus.in_instr, bus.in_pc});
    end
    #1;
    chk("out_valid", 256'(bus.out_valid), 256'(m_ov));
    chk("in_ready", 256'(bus.in_ready), 256'(mq.size() != DEPTH));
    if (m_ov) chk("bundle", 256'(observe()), 256'(m_out));
  endtask

  initial begin
    drive(0, '0, '0, 1, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 256'(bus.out_valid), 256'(0));
    chk("rst_in_ready", 256'(bus.in_ready), 256'(1));
    chk("rst_bundle", 256'(observe()), 256'(0));
    rst_n = 1'b1;

    // Reset mid-stream with three entries queued behind a stalled output.
    for (int i = 0; i < 4; i++) begin
      drive(1, rand_instr(), 32'h200 + 32'(i * 4), 0, 0);
      step();
    end
    chk("pre_rst_count", 256'(dut.count_q), 256'(3));
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", 256'(bus.out_valid), 256'(0));
    chk("async_rst_in_ready", 256'(bus.in_ready), 256'(1));
    chk("async_rst_count", 256'(dut.count_q), 256'(0));
    mq.delete();
    m_ov = 1'b0;
    drive(0, '0, '0, 1, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // addi decode with a negative immediate branch target.
    drive(1, 32'h2041E000, 32'h100, 1, 0);
    step();
    chk("addi_latency_empty", 256'(bus.out_valid), 256'(0));
    drive(0, '0, '0, 1, 0);
    step();
    chk("addi_valid", 256'(bus.out_valid), 256'(1));
    chk("addi_rs", 256'(bus.rs), 256'(2));
    chk("addi_rt", 256'(bus.rt), 256'(1));
    chk("addi_imm", 256'(bus.imm), 256'(16'hE000));
    chk("addi_alu_imm", 256'(bus.alu_imm), 256'(1));
    chk("addi_reg_write", 256'(bus.reg_write), 256'(1));
    chk("addi_btarget", 256'(bus.branch_target), 256'(32'hFFFF8104));
    step();

    // jal target concatenation.
    drive(1, 32'h0C000007, 32'h40, 1, 0);
    step();
    drive(0, '0, '0, 1, 0);
    step();
    chk("jal_jump", 256'(bus.jump), 256'(1));
    chk("jal_link", 256'(bus.jump_link), 256'(1));
    chk("jal_reg_write", 256'(bus.reg_write), 256'(1));
    chk("jal_jtarget", 256'(bus.jump_target), 256'(32'h1C));
    step();

    // Stall: five pushes fill output plus DEPTH entries, then drain in order.
    for (int i = 0; i < 5; i++) begin
      drive(1, rand_instr(), 32'h1000 + 32'(i * 4), 0, 0);
      step();
    end
    chk("full_in_ready", 256'(bus.in_ready), 256'(0));
    chk("full_count", 256'(dut.count_q), 256'(DEPTH));
    drive(1, rand_instr(), 32'h2000, 0, 0);
    step();
    dut_consumed = 0;
    drive(0, '0, '0, 1, 0);
    for (int i = 0; i < 6; i++) step();
    chk("drain_count", 256'(dut_consumed), 256'(5));

    // Flush with two queued and a same-cycle push.
    for (int i = 0; i < 3; i++) begin
      drive(1, rand_instr(), 32'h3000 + 32'(i * 4), 0, 0);
      step();
    end
    drive(1, 32'h2041E000, 32'h4000, 0, 1);
    step();
    chk("flush_out_valid", 256'(bus.out_valid), 256'(0));
    chk("flush_count", 256'(dut.count_q), 256'(0));
    chk("flush_in_ready", 256'(bus.in_ready), 256'(1));
    drive(0, '0, '0, 1, 0);
    step();
    chk("flush_dropped", 256'(bus.out_valid), 256'(0));

    // Unlisted opcode.
    drive(1, 32'hFC0012AB, 32'h500, 1, 0);
    step();
    drive(0, '0, '0, 1, 0);
    step();
    chk("op3f_reg_write", 256'(bus.reg_write), 256'(0));
    chk("op3f_mem_write", 256'(bus.mem_write), 256'(0));
    chk("op3f_alu_op", 256'(bus.alu_op), 256'(0));
    chk("op3f_jump", 256'({bus.jump, bus.jump_reg, bus.branch_eq, bus.alu_imm}), 256'(0));
`ifdef DECODE_ILLEGAL_EN
    chk("op3f_illegal", 256'(bus.illegal), 256'(1));
`endif
    step();

    // Randomized traffic with stalls and occasional flushes.
    for (int i = 0; i < 500; i++) begin
      drive($urandom_range(0, 9) < 6, rand_instr(), $urandom, $urandom_range(0, 9) < 7,
            $urandom_range(0, 31) == 0);
      step();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
